// File: rtl/bin_bcd_seg_pkg.sv
// Shared definitions for the sequential binary-to-BCD seven-segment converter:
// segment pattern constants, FSM state type and the digit-count helper.
package bin_bcd_seg_pkg;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;
    localparam logic [6:0] SEG_D8    = 7'b0000000;
    localparam logic [6:0] SEG_D9    = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Number of decimal digits needed to show 2^width - 1
    function automatic int digits_required(input int width);
        longint unsigned max_val;
        longint unsigned pow;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        n       = 1;
        pow     = 64'd10;
        for (int i = 0; i < 20; i++) begin
            if (pow <= max_val) begin
                n   = n + 1;
                pow = pow * 64'd10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// One BCD digit to active-low seven-segment pattern; codes 10-15 show blank.
module bcd_seg_decode
    import bin_bcd_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup of the display pattern for one digit
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_D0;
            4'd1:    o_seg = SEG_D1;
            4'd2:    o_seg = SEG_D2;
            4'd3:    o_seg = SEG_D3;
            4'd4:    o_seg = SEG_D4;
            4'd5:    o_seg = SEG_D5;
            4'd6:    o_seg = SEG_D6;
            4'd7:    o_seg = SEG_D7;
            4'd8:    o_seg = SEG_D8;
            4'd9:    o_seg = SEG_D9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_bcd_seg_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// registered packed-BCD and active-low seven-segment outputs.
// Optional macro BIN_BCD_SEG_LZB_EN: leading-zero blanking on seg_out
// (digit 0 always shown, bcd_out unaffected).
module bin_bcd_seg_seq
    import bin_bcd_seg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("bin_bcd_seg_seq: WIDTH must be in 1..32");
        end
        if (digits_required(WIDTH) > DIGITS) begin : g_bad_digits
            $error("bin_bcd_seg_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_shift;
    logic               w_latch;
    logic [WIDTH-1:0]   r_shreg;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [ACC_W-1:0]   r_bcd;
    logic [SEG_W-1:0]   r_seg;
    logic [SEG_W-1:0]   w_seg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_latch      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Add-3 correction on every accumulator digit that is 5 or more
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register, accumulator and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shreg <= bin_in;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
        end else if (w_shift) begin
            r_acc   <= {w_acc_adj[ACC_W-2:0], r_shreg[WIDTH-1]};
            r_shreg <= r_shreg << 1;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // Per-digit decoders feeding the output register, optional zero blanking
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            logic [6:0] w_pat;

            bcd_seg_decode u_dec (
                .i_bcd (r_acc[4*i +: 4]),
                .o_seg (w_pat)
            );

`ifdef BIN_BCD_SEG_LZB_EN
            if (i == 0) begin : g_units
                assign w_seg[7*i +: 7] = w_pat;
            end else begin : g_upper
                assign w_seg[7*i +: 7] = (r_acc[ACC_W-1:4*i] == '0) ? SEG_BLANK : w_pat;
            end
`else
            assign w_seg[7*i +: 7] = w_pat;
`endif
        end
    endgenerate

    // Result registers: updated only in LATCH so partial values never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_bcd  <= '0;
            r_seg  <= '1;
        end else begin
            r_done <= w_latch;
            if (w_latch) begin
                r_bcd <= r_acc;
                r_seg <= w_seg;
            end
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign seg_out = r_seg;

endmodule
